// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: pipelined unsigned adder tree that sums INPUTS_NUM words.
//   Each tree level adds neighbouring pairs and registers the result.
//   A new input vector is accepted every clock. Latency is STAGES clocks.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset; clears every pipeline register
//   idata  INPUTS_NUM unsigned words; word i = idata[i*IDATA_WIDTH +: IDATA_WIDTH]
//   odata  registered, overflow-free sum of all words
module adder_tree_pipe #(
  parameter  int unsigned INPUTS_NUM  = 7,
  parameter  int unsigned IDATA_WIDTH = 16,
  localparam int unsigned STAGES      = (INPUTS_NUM > 1) ? $clog2(INPUTS_NUM) : 1,
  localparam int unsigned ODATA_WIDTH = IDATA_WIDTH + $clog2(INPUTS_NUM)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INPUTS_NUM*IDATA_WIDTH-1:0] idata,
  output logic [ODATA_WIDTH-1:0]            odata
);

  // Number of nodes on tree level lvl (level 0 = the input words).
  function automatic int unsigned level_nodes(input int unsigned lvl);
    level_nodes = (INPUTS_NUM + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

  for (genvar k = 0; k <= STAGES; k++) begin : g_lvl
    localparam int unsigned NODES = level_nodes(k);

    for (genvar j = 0; j < NODES; j++) begin : g_node
      logic [ODATA_WIDTH-1:0] node_q;

      if (k == 0) begin : g_leaf
        // Leaves are the raw input words, zero-extended to the sum width.
        assign node_q = ODATA_WIDTH'(idata[j*IDATA_WIDTH +: IDATA_WIDTH]);
      end else begin : g_sum
        localparam int unsigned PREV = level_nodes(k - 1);
        logic [ODATA_WIDTH-1:0] node_d;

        // Pair up children; an unpaired last child is carried forward as-is.
        if (2*j + 1 < PREV) begin : g_pair
          assign node_d = g_lvl[k-1].g_node[2*j].node_q + g_lvl[k-1].g_node[2*j+1].node_q;
        end else begin : g_pass
          assign node_d = g_lvl[k-1].g_node[2*j].node_q;
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            node_q <= '0;
          end else begin
            node_q <= node_d;
          end
        end
      end
    end
  end

  assign odata = g_lvl[STAGES].g_node[0].node_q;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench for adder_tree_pipe: four instances (7, 1, 2 and 8 inputs of 16 bits)
// share one word array and one reset. Each instance has its own reference
// model (sum of the words, delayed by the tree depth, zeroed after reset)
// feeding a scoreboard queue that a negedge monitor drains.
module tb_adder_tree_pipe;

  logic        clk;
  logic        rst;
  logic [15:0] w [8];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar c = 0; c < 4; c++) begin : g_cfg
    localparam int unsigned N  = (c == 0) ? 7 : (c == 1) ? 1 : (c == 2) ? 2 : 8;
    localparam int unsigned S  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned OW = 16 + $clog2(N);

    logic [N*16-1:0] idata;
    logic [OW-1:0]   odata;

    for (genvar i = 0; i < N; i++) begin : g_w
      assign idata[i*16 +: 16] = w[i];
    end

    adder_tree_pipe #(.INPUTS_NUM(N), .IDATA_WIDTH(16)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .idata(idata),
      .odata(odata)
    );

    longint unsigned exp_q[$];
    longint unsigned hist[$];
    int unsigned     since_rst = 0;
    bit              armed     = 1'b0;

    // Reference: output after an edge is the sum sampled S-1 edges earlier,
    // or 0 while fewer than S edges have passed since the last reset edge.
    always @(posedge clk) begin
      longint unsigned s;
      s = 0;
      for (int i = 0; i < int'(N); i++) s += 64'(w[i]);
      if (rst) begin
        armed     = 1'b1;
        since_rst = 0;
        exp_q.push_back(0);
      end else if (armed) begin
        hist.push_back(s);
        if (hist.size() > int'(S)) void'(hist.pop_front());
        if (since_rst < 1000) since_rst++;
        exp_q.push_back((since_rst < S) ? 64'd0 : hist[0]);
      end
    end

    always @(negedge clk) begin
      if (exp_q.size() > 0) begin
        longint unsigned e;
        e = exp_q.pop_front();
        n_checks++;
        if (64'(odata) !== e) begin
          n_fail++;
          $display("FAIL sb_n%0d: odata=%0d expected=%0d", N, odata, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 8; i++) w[i] = v;
  endtask

  task automatic set_rand(input int unsigned maxv);
    for (int i = 0; i < 8; i++) w[i] = 16'($urandom_range(0, maxv));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with random words on the bus.
    rst = 1'b1;
    set_rand(65535);
    step();
    step();
    chk("reset_n7", 64'(g_cfg[0].odata), 0);
    chk("reset_n8", 64'(g_cfg[3].odata), 0);
    rst = 1'b0;
    set_all(16'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_zero", 64'(g_cfg[0].odata), 0);
    end

    // Single vector 1..8, then zeros.
    for (int i = 0; i < 8; i++) w[i] = 16'(i + 1);
    step();
    set_all(16'd0);
    step();
    step();
    chk("seq_n7", 64'(g_cfg[0].odata), 28);
    chk("seq_n8", 64'(g_cfg[3].odata), 36);
    step();
    chk("seq_after_n7", 64'(g_cfg[0].odata), 0);

    // All-ones words: full-width sums must not truncate.
    set_all(16'hFFFF);
    step();
    step();
    step();
    chk("max_n7", 64'(g_cfg[0].odata), 458745);
    chk("max_n8", 64'(g_cfg[3].odata), 524280);
    chk("max_n2", 64'(g_cfg[2].odata), 131070);
    chk("max_n1", 64'(g_cfg[1].odata), 65535);

    // Back-to-back constant vectors c = 1, 2, 3, ...
    for (int c = 1; c <= 12; c++) begin
      set_all(16'(c));
      step();
      if (c >= 3) chk("b2b_n7", 64'(g_cfg[0].odata), 64'(7 * (c - 2)));
    end

    // Reset pulsed mid-stream.
    for (int i = 0; i < 5; i++) begin
      set_rand(65535);
      step();
    end
    rst = 1'b1;
    set_rand(65535);
    step();
    chk("mid_rst_n7", 64'(g_cfg[0].odata), 0);
    chk("mid_rst_n8", 64'(g_cfg[3].odata), 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_rand(65535);
      step();
    end

    // Long random run with 8-bit words.
    for (int i = 0; i < 10000; i++) begin
      set_rand(255);
      step();
    end

    set_all(16'd0);
    for (int i = 0; i < 5; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
